// File: rtl/bcd_counter_7seg_ndisplays.sv
// N-digit BCD up/down counter with tick prescaler, parallel load and a
// registered 7-segment driver (lamp test, leading-zero blanking, polarity).
module bcd_counter_7seg_ndisplays #(
    parameter int DIGITS     = 8,
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  seg7all_on,
    input  logic                  blank_lz,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  tick,
    output logic                  wrap
);

    localparam int              PRESCALE   = CLK_HZ / TICK_HZ;
    localparam int              PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [6:0]      SEG_LIT    = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
    localparam logic [6:0]      SEG_DARK   = ~SEG_LIT;

    logic [PW-1:0]         presc_q, presc_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  tick_q, tick_d;
    logic                  wrap_q, wrap_d;
    logic [7*DIGITS-1:0]   seg_q, seg_d;

    logic [4*DIGITS-1:0]   bcd_up, bcd_dn, bcd_ld;
    logic                  carry, borrow, zero_run, terminal;
    logic [DIGITS-1:0]     blank;
    logic [6:0]            dec_seg [DIGITS];

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0111111;
            4'd1:    seg_decode = 7'b0000110;
            4'd2:    seg_decode = 7'b1011011;
            4'd3:    seg_decode = 7'b1001111;
            4'd4:    seg_decode = 7'b1100110;
            4'd5:    seg_decode = 7'b1101101;
            4'd6:    seg_decode = 7'b1111101;
            4'd7:    seg_decode = 7'b0000111;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // Per-digit load clamping and polarity-corrected decode.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] ld_digit;
            assign ld_digit                = load_value[4*gi +: 4];
            assign bcd_ld[4*gi +: 4]       = (ld_digit > 4'd9) ? 4'd0 : ld_digit;
            assign dec_seg[gi]             = (ACTIVE_LOW != 0) ? ~seg_decode(bcd_q[4*gi +: 4])
                                                               :  seg_decode(bcd_q[4*gi +: 4]);
        end
    endgenerate

    // Ripple carry/borrow; the final carry/borrow flags a full rollover.
    always_comb begin
        carry  = 1'b1;
        borrow = 1'b1;
        bcd_up = bcd_q;
        bcd_dn = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry)
                bcd_up[4*k +: 4] = (bcd_q[4*k +: 4] == 4'd9) ? 4'd0 : bcd_q[4*k +: 4] + 4'd1;
            if (borrow)
                bcd_dn[4*k +: 4] = (bcd_q[4*k +: 4] == 4'd0) ? 4'd9 : bcd_q[4*k +: 4] - 4'd1;
            carry  = carry  & (bcd_q[4*k +: 4] == 4'd9);
            borrow = borrow & (bcd_q[4*k +: 4] == 4'd0);
        end
    end

    assign terminal = enable && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        bcd_d   = bcd_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (load) begin
            presc_d = '0;
            bcd_d   = bcd_ld;
        end else if (terminal) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (up_down) begin
                bcd_d  = bcd_up;
                wrap_d = carry;
            end else begin
                bcd_d  = bcd_dn;
                wrap_d = borrow;
            end
        end else if (enable) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // A digit above digit0 is blanked while it and everything above it is zero.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (bcd_q[4*k +: 4] == 4'd0);
            blank[k] = blank_lz & zero_run;
        end
    end

    always_comb begin
        seg_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (seg7all_on)
                seg_d[7*k +: 7] = SEG_LIT;
            else if (blank[k])
                seg_d[7*k +: 7] = SEG_DARK;
            else
                seg_d[7*k +: 7] = dec_seg[k];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            bcd_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            seg_q   <= {DIGITS{SEG_DARK}};
        end else begin
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
        end
    end

    assign seg_out = seg_q;
    assign bcd_out = bcd_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_counter_7seg_ndisplays.sv
// Scoreboard bench: a decimal-arithmetic model predicts each cycle's outputs,
// which are queued before the edge and compared against the DUT after it.
module tb_bcd_counter_7seg_ndisplays;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 10;
    localparam int MODV     = 10000;
    localparam logic [6:0] SEG_TBL [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    typedef struct {
        logic [15:0] bcd;
        logic        tick;
        logic        wrap;
        logic [27:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, enable, up_down, load, seg7all_on, blank_lz;
    logic [15:0] load_value;
    logic [27:0] seg_out;
    logic [15:0] bcd_out;
    logic        tick, wrap;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_count = 0;
    int   m_presc = 0;

    bcd_counter_7seg_ndisplays #(
        .DIGITS(DIGITS), .CLK_HZ(10), .TICK_HZ(1), .ACTIVE_LOW(1)
    ) dut (
        .clock(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .seg7all_on(seg7all_on),
        .blank_lz(blank_lz), .seg_out(seg_out), .bcd_out(bcd_out),
        .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int from_bcd_clamp(input logic [15:0] v);
        int s, p, d;
        s = 0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            d = int'(v[4*k +: 4]);
            if (d > 9) d = 0;
            s = s + d * p;
            p = p * 10;
        end
        return s;
    endfunction

    function automatic logic [27:0] model_seg(input int cnt, input logic lamp, input logic blz);
        logic [27:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            if (lamp)                        r[7*k +: 7] = 7'h00;
            else if (blz && k > 0 && cnt < p) r[7*k +: 7] = 7'h7F;
            else                             r[7*k +: 7] = ~SEG_TBL[(cnt / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_step(output exp_t e);
        e.tick = 1'b0;
        e.wrap = 1'b0;
        if (reset) begin
            m_count = 0;
            m_presc = 0;
            e.seg   = '1;
        end else begin
            e.seg = model_seg(m_count, seg7all_on, blank_lz);
            if (load) begin
                m_count = from_bcd_clamp(load_value);
                m_presc = 0;
            end else if (enable && m_presc == PRESCALE - 1) begin
                m_presc = 0;
                e.tick  = 1'b1;
                if (up_down) begin
                    e.wrap  = (m_count == MODV - 1);
                    m_count = (m_count + 1) % MODV;
                end else begin
                    e.wrap  = (m_count == 0);
                    m_count = (m_count + MODV - 1) % MODV;
                end
            end else if (enable) begin
                m_presc++;
            end
        end
        e.bcd = to_bcd(m_count);
    endtask

    task automatic cycle();
        exp_t e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_val("bcd", 32'(bcd_out), 32'(e.bcd));
            check_val("tick", 32'(tick), 32'(e.tick));
            check_val("wrap", 32'(wrap), 32'(e.wrap));
            check_val("seg", 32'(seg_out), 32'(e.seg));
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick && n < 30);
        if (!tick) check_val("tick_timeout", 0, 1);
    endtask

    task automatic do_load(input logic [15:0] v);
        load       = 1'b1;
        load_value = v;
        cycle();
        load       = 1'b0;
    endtask

    initial begin
        int n, ticks;
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0;
        load_value = '0; seg7all_on = 1'b0; blank_lz = 1'b0;

        // Reset held across edges
        repeat (2) cycle();
        check_val("rst_seg", 32'(seg_out), 32'h0FFFFFFF);
        check_val("rst_bcd", 32'(bcd_out), 0);

        reset = 1'b0;
        cycle();
        check_val("rel_digit0", 32'(seg_out[6:0]), 32'h40);
        repeat (3) cycle();
        check_val("idle_bcd", 32'(bcd_out), 0);

        seg7all_on = 1'b1;
        cycle();
        check_val("lamp_seg", 32'(seg_out), 0);
        seg7all_on = 1'b0;
        cycle();

        // Up count and rollover
        enable = 1'b1; up_down = 1'b1;
        do_load(16'h9998);
        check_val("up_load", 32'(bcd_out), 32'h9998);
        wait_tick(n);
        check_val("up_period1", n, 10);
        check_val("up_9999", 32'(bcd_out), 32'h9999);
        check_val("up_nowrap", 32'(wrap), 0);
        wait_tick(n);
        check_val("up_period2", n, 10);
        check_val("up_0000", 32'(bcd_out), 0);
        check_val("up_wrap", 32'(wrap), 1);
        cycle();
        check_val("wrap_1cyc", 32'(wrap), 0);

        // Down count with borrow
        up_down = 1'b0;
        do_load(16'h0100);
        wait_tick(n);
        check_val("dn_period", n, 10);
        check_val("dn_0099", 32'(bcd_out), 32'h0099);
        wait_tick(n);
        check_val("dn_0098", 32'(bcd_out), 32'h0098);
        do_load(16'h0000);
        wait_tick(n);
        check_val("dn_9999", 32'(bcd_out), 32'h9999);
        check_val("dn_wrap", 32'(wrap), 1);

        // Load on the prescaler terminal cycle wins and clamps
        up_down = 1'b1;
        while (m_presc != PRESCALE - 1) cycle();
        do_load(16'h12A4);
        check_val("ld_clamp", 32'(bcd_out), 32'h1204);
        check_val("ld_tick", 32'(tick), 0);
        check_val("ld_wrap", 32'(wrap), 0);
        wait_tick(n);
        check_val("ld_period", n, 10);
        check_val("ld_next", 32'(bcd_out), 32'h1205);

        // Enable hold
        while (m_presc != 6) cycle();
        enable = 1'b0;
        ticks  = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tick) ticks++;
        end
        check_val("hold_ticks", ticks, 0);
        enable = 1'b1;
        wait_tick(n);
        check_val("hold_resume", n, 4);

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0050);
        cycle();
        check_val("blz_d3", 32'(seg_out[27:21]), 32'h7F);
        check_val("blz_d2", 32'(seg_out[20:14]), 32'h7F);
        check_val("blz_d1", 32'(seg_out[13:7]), 32'h12);
        check_val("blz_d0", 32'(seg_out[6:0]), 32'h40);
        do_load(16'h0000);
        cycle();
        check_val("blz_zero", 32'(seg_out), 32'h0FFFFFC0);

        // Asynchronous reset mid-period
        repeat (3) cycle();
        #2;
        reset = 1'b1;
        #1;
        m_count = 0;
        m_presc = 0;
        check_val("arst_seg", 32'(seg_out), 32'h0FFFFFFF);
        check_val("arst_bcd", 32'(bcd_out), 0);
        cycle();
        reset = 1'b0;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
